// File: rtl/crossbar_sched_if.sv
// Scheduler bus between the ingress VOQs, the host enable and the crossbar path.
// The host/VOQ side uses master; the scheduler uses slave.
interface crossbar_sched_if #(
  parameter int PORTS = 4
);
  logic                     enable;
  logic [PORTS*PORTS-1:0]   voq_req;
  logic [PORTS*PORTS-1:0]   match;
  logic                     match_valid;
  logic [PORTS-1:0]         deq;
  logic [31:0]              match_count;

  modport master (
    output enable,
    output voq_req,
    input  match,
    input  match_valid,
    input  deq,
    input  match_count
  );

  modport slave (
    input  enable,
    input  voq_req,
    output match,
    output match_valid,
    output deq,
    output match_count
  );
endinterface

// File: rtl/crossbar_sched.sv
// Single-iteration iSLIP crossbar scheduler: grant, accept, then hold the
// conflict-free match for SLOT_LEN cycles while the experiment is enabled.
module crossbar_sched #(
  parameter int PORTS    = 4,
  parameter int SLOT_LEN = 16
) (
  input  logic             clk,
  input  logic             reset,
  crossbar_sched_if.slave  bus
);

  localparam int NN  = PORTS * PORTS;
  localparam int PW  = $clog2(PORTS);
  localparam int CW  = $clog2(SLOT_LEN);
  localparam int PCW = $clog2(PORTS + 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ACCEPT,
    HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [NN-1:0]   grant_q, grant_d;
  logic [NN-1:0]   match_q, match_d;
  logic            match_valid_q, match_valid_d;
  logic [PORTS-1:0] deq_q, deq_d;
  logic [31:0]     match_count_q, match_count_d;
  logic [CW-1:0]   slot_q, slot_d;
  logic [PW-1:0]   grant_ptr  [PORTS];
  logic [PW-1:0]   accept_ptr [PORTS];
  logic [PW-1:0]   grant_ptr_d  [PORTS];
  logic [PW-1:0]   accept_ptr_d [PORTS];

  logic [NN-1:0]    grant_comb;
  logic [NN-1:0]    accept_comb;
  logic [PORTS-1:0] row_any;
  logic [PCW-1:0]   pairs;

  // PORTS need not be a power of two, so the wrap is explicit.
  function automatic logic [PW-1:0] next_ptr(input int idx);
    if (idx + 1 >= PORTS) return '0;
    return PW'(idx + 1);
  endfunction

  // Each egress column grants the first requesting ingress at or after its pointer.
  always_comb begin
    grant_comb = '0;
    for (int j = 0; j < PORTS; j++) begin
      logic found;
      int   idx;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < PORTS; k++) begin
        idx = int'(grant_ptr[j]) + k;
        if (idx >= PORTS) idx = idx - PORTS;
        if (!found && bus.voq_req[idx*PORTS + j]) begin
          grant_comb[idx*PORTS + j] = 1'b1;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    accept_comb = '0;
    for (int i = 0; i < PORTS; i++) begin
      logic found;
      int   idx;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < PORTS; k++) begin
        idx = int'(accept_ptr[i]) + k;
        if (idx >= PORTS) idx = idx - PORTS;
        if (!found && grant_q[i*PORTS + idx]) begin
          accept_comb[i*PORTS + idx] = 1'b1;
          found = 1'b1;
        end
      end
    end
  end

  // Each row holds at most one accepted bit, so matched rows equal matched pairs.
  always_comb begin
    row_any = '0;
    pairs   = '0;
    for (int i = 0; i < PORTS; i++) begin
      row_any[i] = |accept_comb[i*PORTS +: PORTS];
      if (row_any[i]) pairs = pairs + PCW'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    match_d       = match_q;
    match_valid_d = match_valid_q;
    deq_d         = '0;
    match_count_d = match_count_q;
    slot_d        = slot_q;
    grant_ptr_d   = grant_ptr;
    accept_ptr_d  = accept_ptr;
    case (state_q)
      IDLE: begin
        if (bus.enable) state_d = GRANT;
      end
      GRANT: begin
        grant_d = grant_comb;
        state_d = bus.enable ? ACCEPT : IDLE;
      end
      ACCEPT: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (accept_comb == '0) begin
          state_d = GRANT;
        end else begin
          state_d       = HOLD;
          match_d       = accept_comb;
          match_valid_d = 1'b1;
          deq_d         = row_any;
          slot_d        = CW'(SLOT_LEN - 1);
          match_count_d = match_count_q + {{(32-PCW){1'b0}}, pairs};
          for (int i = 0; i < PORTS; i++) begin
            for (int j = 0; j < PORTS; j++) begin
              if (accept_comb[i*PORTS + j]) begin
                grant_ptr_d[j]  = next_ptr(i);
                accept_ptr_d[i] = next_ptr(j);
              end
            end
          end
        end
      end
      HOLD: begin
        // A falling enable only decides where we go once the slot has run out.
        if (slot_q == '0) begin
          match_d       = '0;
          match_valid_d = 1'b0;
          state_d       = bus.enable ? GRANT : IDLE;
        end else begin
          slot_d = slot_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      match_q       <= '0;
      match_valid_q <= 1'b0;
      deq_q         <= '0;
      match_count_q <= '0;
      slot_q        <= '0;
      for (int k = 0; k < PORTS; k++) begin
        grant_ptr[k]  <= '0;
        accept_ptr[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      match_q       <= match_d;
      match_valid_q <= match_valid_d;
      deq_q         <= deq_d;
      match_count_q <= match_count_d;
      slot_q        <= slot_d;
      grant_ptr     <= grant_ptr_d;
      accept_ptr    <= accept_ptr_d;
    end
  end

  assign bus.match       = match_q;
  assign bus.match_valid = match_valid_q;
  assign bus.deq         = deq_q;
  assign bus.match_count = match_count_q;

endmodule

// File: tb/tb_crossbar_sched.sv
// Bench for crossbar_sched: directed scenarios plus random request patterns
// checked against an index-level iSLIP reference model.
module tb_crossbar_sched;

  localparam int P    = 4;
  localparam int SLOT = 16;
  localparam int NN   = P * P;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  int          m_gp [P];
  int          m_ap [P];
  logic [31:0] m_count;

  crossbar_sched_if #(.PORTS(P)) bus ();

  crossbar_sched #(.PORTS(P), .SLOT_LEN(SLOT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    for (int k = 0; k < P; k++) begin
      m_gp[k] = 0;
      m_ap[k] = 0;
    end
    m_count = '0;
  endtask

  // One iSLIP iteration on ingress/egress indices, then pointer and count update.
  task automatic model_slot(input logic [NN-1:0] req, output logic [NN-1:0] em, output logic [P-1:0] ed);
    int gnt [P];
    em = '0;
    ed = '0;
    for (int j = 0; j < P; j++) begin
      gnt[j] = -1;
      for (int k = 0; k < P; k++) begin
        int i = (m_gp[j] + k) % P;
        if (gnt[j] < 0 && req[i*P + j]) gnt[j] = i;
      end
    end
    for (int i = 0; i < P; i++) begin
      for (int k = 0; k < P; k++) begin
        int j = (m_ap[i] + k) % P;
        if (!ed[i] && gnt[j] == i) begin
          em[i*P + j] = 1'b1;
          ed[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < P; i++) begin
      for (int j = 0; j < P; j++) begin
        if (em[i*P + j]) begin
          m_gp[j] = (i + 1) % P;
          m_ap[i] = (j + 1) % P;
          m_count = m_count + 32'd1;
        end
      end
    end
  endtask

  // Waits (bounded) for a slot and records what it looked like; returns on the first low cycle.
  task automatic observe_slot(input logic [NN-1:0] next_req, input int drop_at, input int budget,
                              output int waited, output logic [NN-1:0] m, output logic [P-1:0] d,
                              output logic [31:0] cnt, output int high_len, output bit stable_ok,
                              output bit deq_once);
    waited = 0;
    m = '0; d = '0; cnt = '0; high_len = 0; stable_ok = 1'b0; deq_once = 1'b0;
    while (!bus.match_valid && waited < budget) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.match_valid) return;
    m = bus.match; d = bus.deq; cnt = bus.match_count;
    high_len = 1; stable_ok = 1'b1; deq_once = 1'b1;
    forever begin
      if (high_len == 2) bus.voq_req = next_req;
      if (high_len == drop_at) bus.enable = 1'b0;
      @(posedge clk); #1;
      if (!bus.match_valid) break;
      high_len++;
      if (bus.match !== m) stable_ok = 1'b0;
      if (bus.deq !== '0) deq_once = 1'b0;
      if (high_len > 2*SLOT) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.enable = 1'b1;
    bus.voq_req = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.match !== '0) begin n_fail++; $display("[TB] FAIL reset_match: got %h expected 0", bus.match); end
    n_checks++; if (bus.match_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.match_valid); end
    n_checks++; if (bus.deq !== '0) begin n_fail++; $display("[TB] FAIL reset_deq: got %b expected 0", bus.deq); end
    n_checks++; if (bus.match_count !== '0) begin n_fail++; $display("[TB] FAIL reset_count: got %h expected 0", bus.match_count); end
    reset = 1'b1;
  endtask

  task automatic test_full_contention();
    int w, hl; logic [NN-1:0] m, em; logic [P-1:0] d, ed; logic [31:0] c; bit st, dq;
    observe_slot(16'hFFFF, -1, 20, w, m, d, c, hl, st, dq);
    model_slot(16'hFFFF, em, ed);
    n_checks++; if (w !== 3) begin n_fail++; $display("[TB] FAIL first_latency: got %0d expected 3", w); end
    n_checks++; if (m !== 16'h0001) begin n_fail++; $display("[TB] FAIL contention_slot1: got %h expected 0001", m); end
    n_checks++; if (c !== 32'd1) begin n_fail++; $display("[TB] FAIL contention_count1: got %0d expected 1", c); end
    n_checks++; if (d !== ed) begin n_fail++; $display("[TB] FAIL contention_deq1: got %b expected %b", d, ed); end
    n_checks++; if (hl !== SLOT) begin n_fail++; $display("[TB] FAIL slot_length1: got %0d expected %0d", hl, SLOT); end
    n_checks++; if (!(st && dq)) begin n_fail++; $display("[TB] FAIL hold_stable1: got stable=%b deq_once=%b expected 1 1", st, dq); end
    observe_slot(16'h0800, -1, 20, w, m, d, c, hl, st, dq);
    model_slot(16'hFFFF, em, ed);
    n_checks++; if (w !== 2) begin n_fail++; $display("[TB] FAIL slot_gap: got %0d expected 2", w); end
    n_checks++; if (m !== 16'h0012) begin n_fail++; $display("[TB] FAIL contention_slot2: got %h expected 0012", m); end
    n_checks++; if (c !== 32'd3) begin n_fail++; $display("[TB] FAIL contention_count2: got %0d expected 3", c); end
    n_checks++; if (d !== 4'b0011) begin n_fail++; $display("[TB] FAIL contention_deq2: got %b expected 0011", d); end
  endtask

  task automatic test_single_request();
    int w, hl; logic [NN-1:0] m, em; logic [P-1:0] d, ed; logic [31:0] c; bit st, dq;
    observe_slot('0, -1, 20, w, m, d, c, hl, st, dq);
    model_slot(16'h0800, em, ed);
    n_checks++; if (m !== 16'h0800) begin n_fail++; $display("[TB] FAIL single_match: got %h expected 0800", m); end
    n_checks++; if (d !== 4'b0100) begin n_fail++; $display("[TB] FAIL single_deq: got %b expected 0100", d); end
    n_checks++; if (c !== m_count) begin n_fail++; $display("[TB] FAIL single_count: got %0d expected %0d", c, m_count); end
    n_checks++; if (hl !== SLOT || !st || !dq) begin n_fail++; $display("[TB] FAIL single_hold: got len=%0d stable=%b deq_once=%b expected %0d 1 1", hl, st, dq, SLOT); end
    n_checks++; if (dut.grant_ptr[3] !== 2'd3) begin n_fail++; $display("[TB] FAIL single_grant_ptr: got %0d expected 3", dut.grant_ptr[3]); end
    n_checks++; if (dut.accept_ptr[2] !== 2'd0) begin n_fail++; $display("[TB] FAIL single_accept_ptr: got %0d expected 0", dut.accept_ptr[2]); end
  endtask

  task automatic test_no_requests();
    int w, hl; logic [NN-1:0] m; logic [P-1:0] d; logic [31:0] c; bit st, dq;
    observe_slot('0, -1, 100, w, m, d, c, hl, st, dq);
    n_checks++; if (hl !== 0 || w !== 100) begin n_fail++; $display("[TB] FAIL idle_poll: got len=%0d waited=%0d expected 0 100", hl, w); end
    n_checks++; if (bus.match_count !== m_count) begin n_fail++; $display("[TB] FAIL idle_count: got %0d expected %0d", bus.match_count, m_count); end
  endtask

  task automatic test_random();
    int w, hl; logic [NN-1:0] m, em, req, nreq; logic [P-1:0] d, ed; logic [31:0] c; bit st, dq;
    req = NN'($urandom_range(1, 16'hFFFF));
    bus.voq_req = req;
    for (int s = 0; s < 10; s++) begin
      nreq = NN'($urandom_range(1, 16'hFFFF));
      observe_slot(nreq, -1, 20, w, m, d, c, hl, st, dq);
      model_slot(req, em, ed);
      n_checks++; if (m !== em) begin n_fail++; $display("[TB] FAIL rand_match[%0d]: req %h got %h expected %h", s, req, m, em); end
      n_checks++; if (d !== ed) begin n_fail++; $display("[TB] FAIL rand_deq[%0d]: got %b expected %b", s, d, ed); end
      n_checks++; if (c !== m_count) begin n_fail++; $display("[TB] FAIL rand_count[%0d]: got %0d expected %0d", s, c, m_count); end
      n_checks++; if (hl !== SLOT || !st || !dq) begin n_fail++; $display("[TB] FAIL rand_hold[%0d]: got len=%0d stable=%b deq_once=%b", s, hl, st, dq); end
      if (s > 0) begin
        n_checks++; if (w !== 2) begin n_fail++; $display("[TB] FAIL rand_gap[%0d]: got %0d expected 2", s, w); end
      end
      req = nreq;
    end
    bus.voq_req = req;
  endtask

  task automatic test_disable_mid_slot();
    int w, hl; logic [NN-1:0] m, em; logic [P-1:0] d, ed; logic [31:0] c; bit st, dq;
    logic [NN-1:0] req;
    req = bus.voq_req;
    observe_slot(16'hFFFF, 5, 20, w, m, d, c, hl, st, dq);
    model_slot(req, em, ed);
    n_checks++; if (m !== em) begin n_fail++; $display("[TB] FAIL disable_match: got %h expected %h", m, em); end
    n_checks++; if (hl !== SLOT || !st) begin n_fail++; $display("[TB] FAIL disable_hold: got len=%0d stable=%b expected %0d 1", hl, st, SLOT); end
    observe_slot(16'hFFFF, -1, 40, w, m, d, c, hl, st, dq);
    n_checks++; if (hl !== 0) begin n_fail++; $display("[TB] FAIL disable_idle: got len=%0d expected 0", hl); end
  endtask

  task automatic test_wrap();
    int w, hl; logic [NN-1:0] m, em; logic [P-1:0] d, ed; logic [31:0] c; bit st, dq;
    force dut.match_count_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.match_count_q;
    m_count = 32'hFFFF_FFFF;
    bus.voq_req = 16'h0800;
    bus.enable = 1'b1;
    observe_slot(16'h0800, -1, 20, w, m, d, c, hl, st, dq);
    model_slot(16'h0800, em, ed);
    n_checks++; if (w !== 3) begin n_fail++; $display("[TB] FAIL idle_latency: got %0d expected 3", w); end
    n_checks++; if (m !== em) begin n_fail++; $display("[TB] FAIL wrap_match: got %h expected %h", m, em); end
    n_checks++; if (c !== m_count) begin n_fail++; $display("[TB] FAIL wrap_count: got %h expected %h", c, m_count); end
  endtask

  task automatic test_reset_mid_hold();
    int w;
    bit bad;
    w = 0;
    while (!bus.match_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    n_checks++; if (!bus.match_valid) begin n_fail++; $display("[TB] FAIL midhold_start: got valid=0 expected 1"); end
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_checks++; if (bus.match !== '0 || bus.match_valid !== 1'b0 || bus.deq !== '0) begin
      n_fail++; $display("[TB] FAIL midhold_clear: got match=%h valid=%b deq=%b expected 0 0 0", bus.match, bus.match_valid, bus.deq);
    end
    n_checks++; if (bus.match_count !== '0) begin n_fail++; $display("[TB] FAIL midhold_count: got %h expected 0", bus.match_count); end
    bus.enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.deq !== '0 || bus.match_valid !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("[TB] FAIL midhold_release: got deq/valid activity expected none"); end
  endtask

  initial begin
    test_reset();
    test_full_contention();
    test_single_request();
    test_no_requests();
    test_random();
    test_disable_mid_slot();
    test_wrap();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
